// File: rtl/core_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, forwarding select, redirect flush, memory-busy freeze.
// Define CORE_HAZARD_FORWARD_EN to enable forwarding; otherwise any RAW match stalls until retired.
module core_hazard_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_id_valid,
    input  logic        i_src1_reg_en,
    input  logic        i_src2_reg_en,
    input  logic [4:0]  i_src1_reg_addr,
    input  logic [4:0]  i_src2_reg_addr,
    input  logic [4:0]  i_dst_reg_addr,
    input  logic        i_alures2reg,
    input  logic        i_memory2reg,
    input  logic        i_jal,
    input  logic        i_ex_redirect,
    input  logic        i_mem_busy,
    output logic        o_if_stall,
    output logic        o_id_stall,
    output logic        o_ex_stall,
    output logic        o_if_flush,
    output logic        o_id_bubble,
    output logic [1:0]  o_fwd1_sel,
    output logic [1:0]  o_fwd2_sel,
    output logic [15:0] o_stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } shadow_t;

    shadow_t     ex_q, mem_q, wb_q, ex_d;
    logic [15:0] cnt_q;
    logic        freeze, redirect, hazard;
    logic        s1_ex, s1_mem, s1_wb, s2_ex, s2_mem, s2_wb;

    function automatic logic entry_hit(input shadow_t e, input logic en, input logic [4:0] addr);
        return en && (addr != 5'd0) && e.valid && e.wr && (e.rd == addr);
    endfunction

    assign freeze   = i_mem_busy & mem_q.valid;
    assign redirect = i_ex_redirect & ~freeze;

    assign s1_ex  = i_id_valid & entry_hit(ex_q,  i_src1_reg_en, i_src1_reg_addr);
    assign s1_mem = i_id_valid & entry_hit(mem_q, i_src1_reg_en, i_src1_reg_addr);
    assign s1_wb  = i_id_valid & entry_hit(wb_q,  i_src1_reg_en, i_src1_reg_addr);
    assign s2_ex  = i_id_valid & entry_hit(ex_q,  i_src2_reg_en, i_src2_reg_addr);
    assign s2_mem = i_id_valid & entry_hit(mem_q, i_src2_reg_en, i_src2_reg_addr);
    assign s2_wb  = i_id_valid & entry_hit(wb_q,  i_src2_reg_en, i_src2_reg_addr);

`ifdef CORE_HAZARD_FORWARD_EN
    // Only a load still in EX cannot be forwarded; WB is assumed to write through the regfile.
    logic unused_wb;
    assign unused_wb = ^{wb_q, s1_wb, s2_wb};
    assign hazard    = (s1_ex | s2_ex) & ex_q.load;

    always_comb begin
        o_fwd1_sel = 2'b00;
        o_fwd2_sel = 2'b00;
        if (s1_ex && !ex_q.load) o_fwd1_sel = 2'b01;
        else if (s1_mem)         o_fwd1_sel = 2'b10;
        if (s2_ex && !ex_q.load) o_fwd2_sel = 2'b01;
        else if (s2_mem)         o_fwd2_sel = 2'b10;
    end
`else
    logic unused_wb;
    assign unused_wb  = wb_q.load;
    assign hazard     = s1_ex | s1_mem | s1_wb | s2_ex | s2_mem | s2_wb;
    assign o_fwd1_sel = 2'b00;
    assign o_fwd2_sel = 2'b00;
`endif

    always_comb begin
        ex_d = '0;
        if (i_id_valid && !hazard && !redirect) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = i_dst_reg_addr;
            ex_d.wr    = (i_alures2reg | i_memory2reg) & (i_dst_reg_addr != 5'd0);
            ex_d.load  = i_memory2reg;
        end
    end

    // Outputs are forced low while reset is held, regardless of the inputs.
    always_comb begin
        o_if_stall  = 1'b0;
        o_id_stall  = 1'b0;
        o_ex_stall  = 1'b0;
        o_if_flush  = 1'b0;
        o_id_bubble = 1'b0;
        if (i_rst_n) begin
            if (freeze) begin
                o_if_stall = 1'b1;
                o_id_stall = 1'b1;
                o_ex_stall = 1'b1;
            end else if (redirect) begin
                o_if_flush  = 1'b1;
                o_id_bubble = 1'b1;
            end else if (hazard) begin
                o_if_stall  = 1'b1;
                o_id_stall  = 1'b1;
                o_id_bubble = 1'b1;
            end else if (i_jal && i_id_valid) begin
                o_if_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (!freeze) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                ex_q  <= ex_d;
            end
            if (o_id_stall && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Randomized and directed bench for core_hazard_ctrl against a stage-array reference model.
`timescale 1ns/1ps
module tb_core_hazard_ctrl;
`ifdef CORE_HAZARD_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid, s1_en, s2_en, alu, mem, jal, redirect, busy;
    logic [4:0]  s1_a, s2_a, rd;
    logic        if_stall, id_stall, ex_stall, if_flush, id_bubble;
    logic [1:0]  fwd1, fwd2;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail = 0;

    // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
    bit         m_valid[3];
    logic [4:0] m_rd[3];
    bit         m_wr[3];
    bit         m_load[3];
    int         m_cnt;
    bit         e_freeze, e_redirect, e_hazard, e_stall;

    always #5 clk = ~clk;

    core_hazard_ctrl dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_id_valid      (id_valid),
        .i_src1_reg_en   (s1_en),
        .i_src2_reg_en   (s2_en),
        .i_src1_reg_addr (s1_a),
        .i_src2_reg_addr (s2_a),
        .i_dst_reg_addr  (rd),
        .i_alures2reg    (alu),
        .i_memory2reg    (mem),
        .i_jal           (jal),
        .i_ex_redirect   (redirect),
        .i_mem_busy      (busy),
        .o_if_stall      (if_stall),
        .o_id_stall      (id_stall),
        .o_ex_stall      (ex_stall),
        .o_if_flush      (if_flush),
        .o_id_bubble     (id_bubble),
        .o_fwd1_sel      (fwd1),
        .o_fwd2_sel      (fwd2),
        .o_stall_cnt     (stall_cnt)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit hit(int s, bit en, logic [4:0] a);
        return id_valid && en && a != 5'd0 && m_valid[s] && m_wr[s] && m_rd[s] == a;
    endfunction

    function automatic logic [1:0] fsel(bit en, logic [4:0] a);
        if (!Fwd) return 2'b00;
        if (hit(0, en, a) && !m_load[0]) return 2'b01;
        if (hit(1, en, a)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 3; s++) begin
            m_valid[s] = 0; m_rd[s] = '0; m_wr[s] = 0; m_load[s] = 0;
        end
        m_cnt = 0;
    endtask

    // Compare every DUT output against the model at mid-cycle.
    task automatic sample();
        bit any, ld_use, flush, bubble;
        @(negedge clk);
        e_freeze   = busy && m_valid[1];
        e_redirect = redirect && !e_freeze;
        ld_use = m_load[0] && (hit(0, s1_en, s1_a) || hit(0, s2_en, s2_a));
        any = 0;
        for (int s = 0; s < 3; s++) any = any || hit(s, s1_en, s1_a) || hit(s, s2_en, s2_a);
        e_hazard = Fwd ? ld_use : any;
        e_stall  = e_freeze || (!e_redirect && e_hazard);
        flush    = !e_freeze && (e_redirect || (!e_hazard && jal && id_valid));
        bubble   = !e_freeze && (e_redirect || e_hazard);
        chk("if_stall", {15'd0, if_stall}, {15'd0, e_stall});
        chk("id_stall", {15'd0, id_stall}, {15'd0, e_stall});
        chk("ex_stall", {15'd0, ex_stall}, {15'd0, e_freeze});
        chk("if_flush", {15'd0, if_flush}, {15'd0, flush});
        chk("id_bubble", {15'd0, id_bubble}, {15'd0, bubble});
        chk("fwd1_sel", {14'd0, fwd1}, {14'd0, fsel(s1_en, s1_a)});
        chk("fwd2_sel", {14'd0, fwd2}, {14'd0, fsel(s2_en, s2_a)});
        chk("stall_cnt", stall_cnt, 16'(m_cnt));
    endtask

    task automatic advance();
        bit take;
        take = id_valid && !e_hazard && !e_redirect;
        if (!e_freeze) begin
            for (int s = 2; s > 0; s--) begin
                m_valid[s] = m_valid[s-1]; m_rd[s] = m_rd[s-1];
                m_wr[s] = m_wr[s-1]; m_load[s] = m_load[s-1];
            end
            m_valid[0] = take;
            m_rd[0]    = take ? rd : 5'd0;
            m_wr[0]    = take && (alu || mem) && rd != 5'd0;
            m_load[0]  = take && mem;
        end
        if (e_stall && m_cnt < 65535) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_if_stall", {15'd0, if_stall}, 16'd0);
        chk("rst_id_stall", {15'd0, id_stall}, 16'd0);
        chk("rst_ex_stall", {15'd0, ex_stall}, 16'd0);
        chk("rst_if_flush", {15'd0, if_flush}, 16'd0);
        chk("rst_id_bubble", {15'd0, id_bubble}, 16'd0);
        chk("rst_fwd", {12'd0, fwd1, fwd2}, 16'd0);
        chk("rst_cnt", stall_cnt, 16'd0);
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_id(input bit v, input bit e1, input logic [4:0] a1, input bit e2,
                          input logic [4:0] a2, input logic [4:0] d, input bit w_alu,
                          input bit w_mem, input bit j);
        id_valid = v; s1_en = e1; s1_a = a1; s2_en = e2; s2_a = a2;
        rd = d; alu = w_alu; mem = w_mem; jal = j;
    endtask

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        redirect = 0;
        busy = 0;
        clear_model();
        #1;
        do_reset();

        // lw x5 ; add x6,x5,x1
        set_id(1, 1, 2, 0, 0, 5, 0, 1, 0); sample(); advance();
        set_id(1, 1, 5, 1, 1, 6, 1, 0, 0);
        for (int i = 0; i < (Fwd ? 1 : 3); i++) begin
            sample(); chk("s1_stall", {15'd0, id_stall}, 16'd1);
            chk("s1_bubble", {15'd0, id_bubble}, 16'd1); advance();
        end
        sample(); chk("s1_go", {15'd0, id_stall}, 16'd0);
        chk("s1_fwd1", {14'd0, fwd1}, Fwd ? 16'd2 : 16'd0);
        chk("s1_cnt", stall_cnt, Fwd ? 16'd1 : 16'd3); advance();

        // addi x5 ; add x6,x5,x5
        do_reset();
        set_id(1, 1, 0, 0, 0, 5, 1, 0, 0); sample(); advance();
        set_id(1, 1, 5, 1, 5, 6, 1, 0, 0);
        for (int i = 0; i < (Fwd ? 0 : 3); i++) begin
            sample(); chk("s2_stall", {15'd0, id_stall}, 16'd1); advance();
        end
        sample(); chk("s2_go", {15'd0, id_stall}, 16'd0);
        chk("s2_fwd1", {14'd0, fwd1}, Fwd ? 16'd1 : 16'd0);
        chk("s2_fwd2", {14'd0, fwd2}, Fwd ? 16'd1 : 16'd0); advance();

        // addi x0 ; read x0
        do_reset();
        set_id(1, 1, 3, 0, 0, 0, 1, 0, 0); sample(); advance();
        set_id(1, 1, 0, 1, 0, 7, 1, 0, 0);
        sample(); chk("s3_stall", {15'd0, id_stall}, 16'd0);
        chk("s3_fwd", {12'd0, fwd1, fwd2}, 16'd0); advance();

        // redirect concurrent with load-use
        do_reset();
        set_id(1, 1, 2, 0, 0, 5, 0, 1, 0); sample(); advance();
        set_id(1, 1, 5, 0, 0, 6, 1, 0, 0); redirect = 1;
        sample(); chk("s4_flush", {15'd0, if_flush}, 16'd1);
        chk("s4_bubble", {15'd0, id_bubble}, 16'd1);
        chk("s4_stall", {15'd0, id_stall}, 16'd0); advance();
        redirect = 0;

        // JAL flush, and JAL suppressed by a hazard
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 1, 0, 1);
        sample(); chk("jal_flush", {15'd0, if_flush}, 16'd1); advance();
        set_id(1, 1, 1, 0, 0, 2, 1, 0, 1);
        sample(); chk("jal_hazard_flush", {15'd0, if_flush}, Fwd ? 16'd1 : 16'd0); advance();

        // freeze with deferred redirect
        do_reset();
        set_id(1, 1, 2, 0, 0, 7, 0, 1, 0); sample(); advance();
        set_id(1, 1, 3, 1, 4, 0, 0, 0, 0); sample(); advance();
        set_id(1, 1, 10, 0, 0, 9, 1, 0, 0); busy = 1; redirect = 1;
        for (int i = 0; i < 4; i++) begin
            sample(); chk("s5_ex_stall", {15'd0, ex_stall}, 16'd1);
            chk("s5_id_stall", {15'd0, id_stall}, 16'd1);
            chk("s5_flush", {15'd0, if_flush}, 16'd0);
            chk("s5_bubble", {15'd0, id_bubble}, 16'd0); advance();
        end
        busy = 0;
        sample(); chk("s5_flush5", {15'd0, if_flush}, 16'd1);
        chk("s5_bubble5", {15'd0, id_bubble}, 16'd1);
        chk("s5_cnt", stall_cnt, 16'd4); advance();
        redirect = 0;

        // reset dropped mid-freeze
        do_reset();
        set_id(1, 1, 2, 0, 0, 7, 0, 1, 0); sample(); advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); sample(); advance();
        set_id(1, 1, 7, 1, 7, 8, 1, 0, 1); busy = 1; redirect = 1;
        sample(); advance();
        sample(); chk("s6_stall", {15'd0, id_stall}, 16'd1);
        chk("s6_cnt", stall_cnt, 16'd1);
        do_reset();
        busy = 0; redirect = 0;
        sample(); chk("s6_after", {15'd0, id_stall}, 16'd0);
        chk("s6_after_fwd", {14'd0, fwd1}, 16'd0); advance();

        // randomized traffic on a small register set to provoke hazards
        for (int c = 0; c < 4000; c++) begin
            id_valid = $urandom_range(0, 9) != 0;
            s1_en    = 1'($urandom_range(0, 1));
            s2_en    = 1'($urandom_range(0, 1));
            s1_a     = 5'($urandom_range(0, 3));
            s2_a     = 5'($urandom_range(0, 3));
            rd       = 5'($urandom_range(0, 3));
            alu      = 1'($urandom_range(0, 1));
            mem      = $urandom_range(0, 2) == 0;
            jal      = $urandom_range(0, 7) == 0;
            redirect = $urandom_range(0, 9) == 0;
            busy     = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 399) == 0) do_reset();
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_hazard_ctrl.md
CORE_HAZARD_CTRL -- requirements
Module: core_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: i_clk  in  1  rising-edge clock; i_rst_n  in  1  async active-low reset.
REQ-002 The block SHALL have these ID-side inputs:
- i_id_valid  in  1  ID holds a valid instruction.
- i_src1_reg_en / i_src2_reg_en  in  1  rs1 / rs2 are read.
- i_src1_reg_addr / i_src2_reg_addr / i_dst_reg_addr  in  5  rs1, rs2, rd.
- i_alures2reg / i_memory2reg  in  1  ALU-result writeback / load writeback.
- i_jal  in  1  JAL in ID.
REQ-003 The block SHALL have these other inputs:
- i_ex_redirect  in  1  taken branch or JALR resolved in EX.
- i_mem_busy  in  1  data memory not ready for the MEM-stage access.
REQ-004 The block SHALL have these outputs:
- o_if_stall / o_id_stall  out  1  hold PC / hold IF-ID register.
- o_ex_stall  out  1  freeze EX, MEM, WB.
- o_if_flush  out  1  kill the instruction entering ID.
- o_id_bubble  out  1  insert a NOP into EX.
- o_fwd1_sel / o_fwd2_sel  out  2  operand source for the instruction leaving ID: 00 = regfile, 01 = EX result, 10 = MEM result.
- o_stall_cnt  out  16  saturating stall-cycle counter.

Function
REQ-005 Three shadow entries (EX, MEM, WB) SHALL each hold {valid, rd, wr = alures2reg|memory2reg, load = memory2reg}; an entry with rd==0 SHALL be treated as wr=0.
REQ-006 When not frozen, on each clock: WB<=MEM, MEM<=EX; EX<=ID fields if i_id_valid and no hazard stall and no redirect, else EX<=invalid.
REQ-007 Freeze = i_mem_busy & MEM.valid; while frozen, all shadows SHALL hold and o_if_stall=o_id_stall=o_ex_stall=1, o_id_bubble=0.
REQ-008 Match(s) = ID src enabled & addr!=0 & entry.valid & entry.wr & entry.rd==addr.
REQ-009 A load-use hazard (Match against EX with EX.load) SHALL assert o_if_stall, o_id_stall and o_id_bubble for exactly one cycle per dependent instruction.
REQ-010 Forward select SHALL be 01 on a non-load Match with EX, else 10 on a Match with MEM, else 00; EX SHALL have priority over MEM.
REQ-011 i_ex_redirect (when not frozen) SHALL assert o_if_flush and o_id_bubble, SHALL suppress any hazard stall that cycle, and SHALL force the EX shadow invalid.
REQ-012 i_jal with i_id_valid, no stall and no redirect SHALL assert o_if_flush for one cycle.
REQ-013 Redirect under freeze SHALL be deferred: the block SHALL act on it in the first non-frozen cycle, because EX holds it.
REQ-014 Priority SHALL be: freeze > redirect > hazard stall > JAL flush.
REQ-015 o_stall_cnt SHALL increment in every cycle with o_id_stall=1 and saturate at 16'hFFFF.
REQ-016 All control outputs SHALL be combinational from the shadows and inputs, valid in the same cycle.

Reset
REQ-017 While i_rst_n=0, all shadow valids SHALL be 0, o_stall_cnt SHALL be 0, and all control outputs SHALL be 0 / 00.
REQ-018 Reset asserted mid-stall or mid-freeze SHALL clear state immediately; after release the first instruction SHALL see no hazard.

Configuration
REQ-019 Macro CORE_HAZARD_FORWARD_EN: when defined, behaviour is per REQ-009/010.
REQ-020 When CORE_HAZARD_FORWARD_EN is undefined, o_fwd*_sel SHALL be tied to 00, and any Match against EX, MEM or WB SHALL stall with a bubble until no Match remains (up to 3 cycles).

Verification
REQ-021 Scenario 1: lw x5 then add x6,x5,x1 -> one cycle with o_id_stall=1 and o_id_bubble=1, then o_fwd1_sel=10, o_stall_cnt=1.
REQ-022 Scenario 2: addi x5 then add x6,x5,x5 -> no stall; o_fwd1_sel=o_fwd2_sel=01 (macro off: 3 stall cycles, sel=00).
REQ-023 Scenario 3: addi x0 then read x0 -> no stall, sel=00.
REQ-024 Scenario 4: i_ex_redirect=1 concurrent with a load-use hazard in ID -> o_if_flush=1, o_id_bubble=1, o_id_stall=0.
REQ-025 Scenario 5: i_mem_busy=1 for 4 cycles with a load in MEM and i_ex_redirect=1 -> 4 frozen cycles, o_stall_cnt+=4, then flush in cycle 5.
REQ-026 Scenario 6: i_rst_n dropped during a stall -> all outputs 0 asynchronously; o_stall_cnt=0.
